// File: rtl/ctrl_pipe_hazard.sv
// Decode-to-writeback control pipeline: carries the control bundle and rd through ID/EX, EX/MEM and MEM/WB,
// resolves load-use stalls and redirect flushes, and keeps saturating stall/flush cycle counters.
module ctrl_pipe_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_2_reg,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_2_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]            ex_alu_op_r;
    logic                  ex_alu_src_r, ex_branch_r, ex_jump_r, ex_mem_read_r;
    logic                  ex_mem_write_r, ex_mem_2_reg_r, ex_reg_write_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  mem_mem_read_r, mem_mem_write_r, mem_mem_2_reg_r, mem_reg_write_r;
    logic [REG_ADDR_W-1:0] mem_rd_r;
    logic                  wb_mem_2_reg_r, wb_reg_write_r;
    logic [REG_ADDR_W-1:0] wb_rd_r;
    logic [CNT_W-1:0]      stall_cnt_r, flush_cnt_r;
    logic                  haz_s, kill_id_s, stall_s;

    // Load-use detection against the instruction in EX; x0 never creates a dependency.
    always_comb begin
        haz_s     = 1'b0;
        kill_id_s = 1'b0;
        stall_s   = 1'b0;
        if (ex_mem_read_r && (ex_rd_r != {REG_ADDR_W{1'b0}}) &&
            ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2))) begin
            haz_s = 1'b1;
        end else begin
            haz_s = 1'b0;
        end
        // A redirect makes the ID instruction wrong-path, so it wins over the stall.
        kill_id_s = haz_s | ex_redirect;
        stall_s   = haz_s & ~ex_redirect;
    end

    // ID/EX register: takes the ID bundle or a bubble when the ID slot is stalled or squashed.
    always_ff @(posedge clk) begin
        if (rst || (en && kill_id_s)) begin
            ex_alu_op_r    <= 2'b00;
            ex_alu_src_r   <= 1'b0;
            ex_branch_r    <= 1'b0;
            ex_jump_r      <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_mem_2_reg_r <= 1'b0;
            ex_reg_write_r <= 1'b0;
            ex_rd_r        <= {REG_ADDR_W{1'b0}};
        end else if (en) begin
            ex_alu_op_r    <= id_alu_op;
            ex_alu_src_r   <= id_alu_src;
            ex_branch_r    <= id_branch;
            ex_jump_r      <= id_jump;
            ex_mem_read_r  <= id_mem_read;
            ex_mem_write_r <= id_mem_write;
            ex_mem_2_reg_r <= id_mem_2_reg;
            ex_reg_write_r <= id_reg_write;
            ex_rd_r        <= id_rd;
        end
    end

    // EX/MEM and MEM/WB registers: plain shift, never stalled or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_mem_read_r  <= 1'b0;
            mem_mem_write_r <= 1'b0;
            mem_mem_2_reg_r <= 1'b0;
            mem_reg_write_r <= 1'b0;
            mem_rd_r        <= {REG_ADDR_W{1'b0}};
            wb_mem_2_reg_r  <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_rd_r         <= {REG_ADDR_W{1'b0}};
        end else if (en) begin
            mem_mem_read_r  <= ex_mem_read_r;
            mem_mem_write_r <= ex_mem_write_r;
            mem_mem_2_reg_r <= ex_mem_2_reg_r;
            mem_reg_write_r <= ex_reg_write_r;
            mem_rd_r        <= ex_rd_r;
            wb_mem_2_reg_r  <= mem_mem_2_reg_r;
            wb_reg_write_r  <= mem_reg_write_r;
            wb_rd_r         <= mem_rd_r;
        end
    end

    // Saturating performance counters for stall and redirect cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (ex_redirect && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign ex_alu_op     = ex_alu_op_r;
    assign ex_alu_src    = ex_alu_src_r;
    assign ex_branch     = ex_branch_r;
    assign ex_jump       = ex_jump_r;
    assign ex_mem_read   = ex_mem_read_r;
    assign ex_rd         = ex_rd_r;
    assign mem_mem_read  = mem_mem_read_r;
    assign mem_mem_write = mem_mem_write_r;
    assign mem_mem_2_reg = mem_mem_2_reg_r;
    assign mem_reg_write = mem_reg_write_r;
    assign mem_rd        = mem_rd_r;
    assign wb_mem_2_reg  = wb_mem_2_reg_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_rd         = wb_rd_r;
    assign stall_if_id   = stall_s;
    assign flush_if_id   = ex_redirect;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed vector table, a counter-saturation sequence on a CNT_W=2 copy,
// and random traffic against a three-slot pipeline model.
module tb_ctrl_pipe_hazard;

    localparam logic [8:0] C_NOP = 9'b00_0_0_0_0_0_0_0;
    localparam logic [8:0] C_R   = 9'b10_0_0_0_0_0_0_1;
    localparam logic [8:0] C_LD  = 9'b00_1_0_0_1_0_1_1;

    logic       clk = 1'b0;
    logic       rst, en, ex_redirect;
    logic [1:0] id_alu_op;
    logic       id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0] ex_alu_op, d2_ex_alu_op;
    logic       ex_alu_src, ex_branch, ex_jump, ex_mem_read;
    logic       d2_ex_alu_src, d2_ex_branch, d2_ex_jump, d2_ex_mem_read;
    logic [4:0] ex_rd, mem_rd, wb_rd, d2_ex_rd, d2_mem_rd, d2_wb_rd;
    logic       mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write;
    logic       d2_mem_mem_read, d2_mem_mem_write, d2_mem_mem_2_reg, d2_mem_reg_write;
    logic       wb_mem_2_reg, wb_reg_write, d2_wb_mem_2_reg, d2_wb_reg_write;
    logic       stall_if_id, flush_if_id, d2_stall_if_id, d2_flush_if_id;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_hazard #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
        .id_reg_write(id_reg_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_2_reg(mem_mem_2_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_mem_2_reg(wb_mem_2_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipe_hazard #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
        .id_reg_write(id_reg_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_alu_op(d2_ex_alu_op), .ex_alu_src(d2_ex_alu_src), .ex_branch(d2_ex_branch), .ex_jump(d2_ex_jump),
        .ex_mem_read(d2_ex_mem_read), .ex_rd(d2_ex_rd),
        .mem_mem_read(d2_mem_mem_read), .mem_mem_write(d2_mem_mem_write), .mem_mem_2_reg(d2_mem_mem_2_reg),
        .mem_reg_write(d2_mem_reg_write), .mem_rd(d2_mem_rd),
        .wb_mem_2_reg(d2_wb_mem_2_reg), .wb_reg_write(d2_wb_reg_write), .wb_rd(d2_wb_rd),
        .stall_if_id(d2_stall_if_id), .flush_if_id(d2_flush_if_id),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    // Model: slot 0 = EX, 1 = MEM, 2 = WB; ctrl = {alu_op, alu_src, branch, jump, mem_read, mem_write, mem_2_reg, reg_write}
    typedef struct packed {
        logic [8:0] ctrl;
        logic [4:0] rd;
    } stage_t;

    typedef struct {
        logic       rst, en, redir;
        logic [8:0] ctrl;
        logic [4:0] rs1, rs2, rd;
        logic       e_stall, e_flush;
        logic [4:0] e_ex_rd;
        logic       e_ex_mr;
        logic [4:0] e_mem_rd, e_wb_rd;
        logic       e_wb_rw;
        int         e_scnt, e_fcnt;
    } vec_t;

    stage_t pipe [3];
    int     m_scnt, m_fcnt;
    int     n_chk = 0;
    int     n_err = 0;
    vec_t   tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_haz();
        return pipe[0].ctrl[3] && (pipe[0].rd != 5'd0) && ((pipe[0].rd == id_rs1) || (pipe[0].rd == id_rs2));
    endfunction

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [26:0] model_vec();
        return {pipe[0].ctrl[8:3], pipe[0].rd, pipe[1].ctrl[3:0], pipe[1].rd, pipe[2].ctrl[1:0], pipe[2].rd};
    endfunction

    function automatic vec_t mk(input logic r, e, x, input logic [8:0] c, input int s1, s2, d,
                                input logic es, ef, input int erd, input logic emr,
                                input int emem, ewb, input logic ewr, input int sc, fc);
        vec_t v;
        v.rst = r; v.en = e; v.redir = x; v.ctrl = c;
        v.rs1 = s1[4:0]; v.rs2 = s2[4:0]; v.rd = d[4:0];
        v.e_stall = es; v.e_flush = ef; v.e_ex_rd = erd[4:0]; v.e_ex_mr = emr;
        v.e_mem_rd = emem[4:0]; v.e_wb_rd = ewb[4:0]; v.e_wb_rw = ewr;
        v.e_scnt = sc; v.e_fcnt = fc;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge and check the combinational outputs against the model.
    task automatic apply(input logic r, e, x, input logic [8:0] c, input logic [4:0] s1, s2, d, input bit do_chk);
        logic exp_stall;
        rst = r; en = e; ex_redirect = x;
        {id_alu_op, id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write} = c;
        id_rs1 = s1; id_rs2 = s2; id_rd = d;
        #1;
        exp_stall = model_haz() & ~x;
        if (do_chk) begin
            chk("stall_if_id", {31'd0, stall_if_id}, {31'd0, exp_stall});
            chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, x});
            chk("d2_stall_if_id", {31'd0, d2_stall_if_id}, {31'd0, exp_stall});
        end
    endtask

    // Clock edge, advance the model, then check every registered output of both instances.
    task automatic tick(input bit do_chk);
        logic   h;
        stage_t id_s;
        h = model_haz();
        id_s.ctrl = {id_alu_op, id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write};
        id_s.rd = id_rd;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else if (en) begin
            if (h && !ex_redirect) m_scnt++;
            if (ex_redirect) m_fcnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (h || ex_redirect) ? stage_t'(0) : id_s;
        end
        if (do_chk) begin
            chk("pipe_regs", {5'd0, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_rd,
                              mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write, mem_rd,
                              wb_mem_2_reg, wb_reg_write, wb_rd}, {5'd0, model_vec()});
            chk("d2_pipe_regs", {5'd0, d2_ex_alu_op, d2_ex_alu_src, d2_ex_branch, d2_ex_jump, d2_ex_mem_read, d2_ex_rd,
                                 d2_mem_mem_read, d2_mem_mem_write, d2_mem_mem_2_reg, d2_mem_reg_write, d2_mem_rd,
                                 d2_wb_mem_2_reg, d2_wb_reg_write, d2_wb_rd}, {5'd0, model_vec()});
            chk("stall_cnt", {16'd0, stall_cnt}, sat(m_scnt, 65535));
            chk("flush_cnt", {16'd0, flush_cnt}, sat(m_fcnt, 65535));
            chk("d2_stall_cnt", {30'd0, d2_stall_cnt}, sat(m_scnt, 3));
            chk("d2_flush_cnt", {30'd0, d2_flush_cnt}, sat(m_fcnt, 3));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_scnt = 0;
        m_fcnt = 0;

        // rst, en, redir, ctrl, rs1, rs2, rd | stall, flush | ex_rd, ex_mr, mem_rd, wb_rd, wb_rw, scnt, fcnt
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, C_R,   0, 0, 5,  1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, C_R,   1, 2, 5,  1'b0, 1'b0, 5, 1'b0, 0, 0, 1'b0, 0, 0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, C_NOP, 0, 0, 0,  1'b0, 1'b0, 0, 1'b0, 5, 0, 1'b0, 0, 0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, C_NOP, 0, 0, 0,  1'b0, 1'b0, 0, 1'b0, 0, 5, 1'b1, 0, 0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, C_LD,  2, 3, 7,  1'b0, 1'b0, 7, 1'b1, 0, 0, 1'b0, 0, 0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, C_R,   7, 4, 9,  1'b1, 1'b0, 0, 1'b0, 7, 0, 1'b0, 1, 0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, C_R,   7, 4, 9,  1'b0, 1'b0, 9, 1'b0, 0, 7, 1'b1, 1, 0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, C_LD,  0, 0, 0,  1'b0, 1'b0, 0, 1'b1, 9, 0, 1'b0, 1, 0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, C_R,   3, 0, 6,  1'b0, 1'b0, 6, 1'b0, 0, 9, 1'b1, 1, 0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, C_LD,  1, 1, 8,  1'b0, 1'b0, 8, 1'b1, 6, 0, 1'b1, 1, 0);
        tbl[10] = mk(1'b0, 1'b1, 1'b1, C_R,   0, 8, 10, 1'b0, 1'b1, 0, 1'b0, 8, 6, 1'b1, 1, 1);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, C_NOP, 0, 0, 0,  1'b0, 1'b0, 0, 1'b0, 0, 8, 1'b1, 1, 1);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, C_LD,  0, 0, 3,  1'b0, 1'b0, 0, 1'b0, 0, 8, 1'b1, 1, 1);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, C_LD,  0, 0, 3,  1'b0, 1'b0, 3, 1'b1, 0, 0, 1'b0, 1, 1);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, C_R,   3, 0, 3,  1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);

        // Two cycles of reset, then the table.
        apply(1'b1, 1'b1, 1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(1'b0);
        apply(1'b1, 1'b1, 1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(1'b1);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].redir, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 1'b1);
            chk($sformatf("tbl%0d_stall", i), {31'd0, stall_if_id}, {31'd0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_flush", i), {31'd0, flush_if_id}, {31'd0, tbl[i].e_flush});
            tick(1'b1);
            chk($sformatf("tbl%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].e_ex_rd});
            chk($sformatf("tbl%0d_ex_mr", i), {31'd0, ex_mem_read}, {31'd0, tbl[i].e_ex_mr});
            chk($sformatf("tbl%0d_mem_rd", i), {27'd0, mem_rd}, {27'd0, tbl[i].e_mem_rd});
            chk($sformatf("tbl%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, tbl[i].e_wb_rd});
            chk($sformatf("tbl%0d_wb_rw", i), {31'd0, wb_reg_write}, {31'd0, tbl[i].e_wb_rw});
            chk($sformatf("tbl%0d_scnt", i), {16'd0, stall_cnt}, tbl[i].e_scnt);
            chk($sformatf("tbl%0d_fcnt", i), {16'd0, flush_cnt}, tbl[i].e_fcnt);
        end

        // Five load-use stalls, then en=0 for three cycles with a hazard sitting in EX/ID.
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 1'b0, C_LD, 5'd0, 5'd0, 5'd7, 1'b1);
            tick(1'b1);
            apply(1'b0, 1'b1, 1'b0, C_R, 5'd7, 5'd2, 5'd4, 1'b1);
            chk("sat_seq_stall", {31'd0, stall_if_id}, 32'd1);
            tick(1'b1);
        end
        apply(1'b0, 1'b1, 1'b0, C_LD, 5'd0, 5'd0, 5'd7, 1'b1);
        tick(1'b1);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 1'b0, C_R, 5'd7, 5'd2, 5'd4, 1'b1);
            chk("hold_stall", {31'd0, d2_stall_if_id}, 32'd1);
            tick(1'b1);
            chk("hold_ex_rd", {27'd0, d2_ex_rd}, 32'd7);
            chk("hold_ex_mr", {31'd0, d2_ex_mem_read}, 32'd1);
            chk("sat_d2_stall_cnt", {30'd0, d2_stall_cnt}, 32'd3);
            chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'd5);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [8:0] c;
            c = 9'($urandom);
            c[3] = ($urandom_range(0, 2) != 0);
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0), c,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1);
            tick(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
